trig_window_ctrl: RTL

TRIG_WINDOW_CTRL -- requirements
Module: trig_window_ctrl

---
 rtl/trig_window_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/trig_window_ctrl.sv
// Trigger-window controller: arms on a qualified trigger edge, writes CAP_LEN words into the channel FIFOs, then holds off.
// Optional trigger timestamp is enabled by defining TRIG_TIMESTAMP_EN.
module trig_window_ctrl #(
  parameter int CAP_LEN = 64,
  parameter int HOLDOFF = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        trig_a,
  input  logic        trig_b,
  input  logic [1:0]  trig_mask,
  input  logic        ff_a,
  input  logic        ff_b,
  input  logic        ovf_clr,
  output logic        fifo_wr,
  output logic        busy,
  output logic [15:0] evt_cnt,
  output logic        ovf,
  output logic [31:0] ts,
  output logic        ts_vld
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_HOLD
  } state_t;

  localparam logic [15:0] LAST_WR = 16'(CAP_LEN - 1);
  localparam logic [16:0] HOLD_N  = 17'(HOLDOFF);

  state_t      state;
  logic [15:0] wr_cnt;
  logic [15:0] hold_cnt;
  logic        trig_q;
  logic        trig_or;
  logic        trig_edge;
  logic        full;
  logic        accept;
  logic        lost;
  logic        trunc;
  logic        hold_done;

  assign trig_or   = (trig_a & trig_mask[0]) | (trig_b & trig_mask[1]);
  assign trig_edge = trig_or & ~trig_q;
  assign full      = ff_a | ff_b;
  assign accept    = (state == S_ARMED) & arm & trig_edge & ~full;
  assign lost      = (state == S_ARMED) & arm & trig_edge & full;
  assign trunc     = (state == S_CAPTURE) & full;
  assign hold_done = ({1'b0, hold_cnt} + 17'd1) >= HOLD_N;

  // Writes stop the very cycle either FIFO reports full.
  assign fifo_wr = (state == S_CAPTURE) & ~full;
  assign busy    = (state == S_CAPTURE) | (state == S_HOLD);

  // Registered copy of the qualified trigger OR for edge detection.
  always_ff @(posedge clk) begin
    if (rst) trig_q <= 1'b0;
    else     trig_q <= trig_or;
  end

  // Sticky overflow; a new loss wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst)                ovf <= 1'b0;
    else if (lost | trunc)  ovf <= 1'b1;
    else if (ovf_clr)       ovf <= 1'b0;
  end

  // Capture window state machine with write and holdoff counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wr_cnt   <= '0;
      hold_cnt <= '0;
      evt_cnt  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (arm) state <= S_ARMED;
        end
        S_ARMED: begin
          if (!arm) begin
            state <= S_IDLE;
          end else if (accept) begin
            state  <= S_CAPTURE;
            wr_cnt <= '0;
          end
        end
        S_CAPTURE: begin
          if (full) begin
            state    <= S_HOLD;
            hold_cnt <= '0;
          end else if (wr_cnt == LAST_WR) begin
            state    <= S_HOLD;
            hold_cnt <= '0;
            evt_cnt  <= evt_cnt + 16'd1;
          end else begin
            wr_cnt <= wr_cnt + 16'd1;
          end
        end
        S_HOLD: begin
          if (hold_done) state <= arm ? S_ARMED : S_IDLE;
          else           hold_cnt <= hold_cnt + 16'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TRIG_TIMESTAMP_EN
  logic [31:0] cyc_cnt;

  // Free-running cycle counter latched on each accepted trigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
      ts      <= '0;
      ts_vld  <= 1'b0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      ts_vld  <= accept;
      if (accept) ts <= cyc_cnt;
    end
  end
`else
  assign ts     = '0;
  assign ts_vld = 1'b0;
`endif

endmodule
